// File: rtl/lcd_reset_seq_pkg.sv
// Shared ILI9341 definitions: pin levels, reset-sequencer state encoding, SWRESET opcode.
// Used by lcd_reset_seq (soft reset enabled by LCD_RESET_SEQ_SOFT_RESET_EN) and the init controller.
package pkg_ili9341;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;
  localparam logic ON   = 1'b1;
  localparam logic OFF  = 1'b0;

  localparam logic [7:0] CMD_SWRESET_DEF = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_PULSE     = 3'd2,
    ST_WAIT      = 3'd3,
    ST_SOFT_REQ  = 3'd4,
    ST_SOFT_WAIT = 3'd5,
    ST_DONE      = 3'd6
  } rst_seq_state_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_reset_seq_timer.sv
// seq_timer: loadable down-counter that stops at zero; shared by reset and init delay states.
module seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/lcd_reset_seq.sv
// ILI9341 power-on reset sequencer: RESX pre-hold, low pulse, recovery, done strobe.
// Define LCD_RESET_SEQ_SOFT_RESET_EN to follow recovery with a SWRESET command handshake.
module lcd_reset_seq
  import pkg_ili9341::*;
#(
  parameter int unsigned PRE_CYC       = 1_000,
  parameter int unsigned PULSE_CYC     = 1_000,
  parameter int unsigned WAIT_CYC      = 12_000_000,
  parameter int unsigned SOFT_WAIT_CYC = 500_000,
  parameter logic [7:0]  CMD_SWRESET   = CMD_SWRESET_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_abort,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_resx,
  output logic       o_cmd_valid,
  output logic [7:0] o_cmd_data,
  input  logic       i_cmd_ready
);

  localparam int unsigned MAX_CYC = max2(max2(PRE_CYC, PULSE_CYC), max2(WAIT_CYC, SOFT_WAIT_CYC));
  localparam int          CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_CYC - 1);

  rst_seq_state_e   r_state;
  rst_seq_state_e   w_nxt;
  logic [CNT_W-1:0] w_ld_val;
  logic             w_load;
  logic             w_zero;
  logic             r_busy;
  logic             r_done;
  logic             r_resx;

  // Every state change reloads the counter, so untimed states always see it at 0.
  seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst),
    .i_load     (w_load),
    .i_load_val (w_ld_val),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_nxt    = r_state;
    w_ld_val = '0;
    case (r_state)
      ST_IDLE:      if (i_start && !i_abort) w_nxt = ST_PRE;
      ST_PRE:       if (w_zero) w_nxt = ST_PULSE;
      ST_PULSE:     if (w_zero) w_nxt = ST_WAIT;
`ifdef LCD_RESET_SEQ_SOFT_RESET_EN
      ST_WAIT:      if (w_zero) w_nxt = ST_SOFT_REQ;
      ST_SOFT_REQ:  if (i_cmd_ready) w_nxt = ST_SOFT_WAIT;
      ST_SOFT_WAIT: if (w_zero) w_nxt = ST_DONE;
`else
      ST_WAIT:      if (w_zero) w_nxt = ST_DONE;
`endif
      ST_DONE:      w_nxt = ST_IDLE;
      default:      w_nxt = ST_IDLE;
    endcase
    if (i_abort && (r_state != ST_IDLE)) w_nxt = ST_IDLE;

    case (w_nxt)
      ST_PRE:       w_ld_val = PRE_LD;
      ST_PULSE:     w_ld_val = PULSE_LD;
      ST_WAIT:      w_ld_val = WAIT_LD;
`ifdef LCD_RESET_SEQ_SOFT_RESET_EN
      ST_SOFT_WAIT: w_ld_val = CNT_W'(SOFT_WAIT_CYC - 1);
`endif
      default:      w_ld_val = '0;
    endcase
  end

  assign w_load = (w_nxt != r_state);

`ifdef LCD_RESET_SEQ_SOFT_RESET_EN
  logic       r_cmd_valid;
  logic [7:0] r_cmd_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd_valid <= OFF;
      r_cmd_data  <= '0;
    end else begin
      r_cmd_valid <= (w_nxt == ST_SOFT_REQ);
      r_cmd_data  <= (w_nxt == ST_SOFT_REQ) ? CMD_SWRESET : 8'h00;
    end
  end

  assign o_cmd_valid = r_cmd_valid;
  assign o_cmd_data  = r_cmd_data;
`else
  logic w_unused;
  assign w_unused    = &{1'b0, i_cmd_ready, CMD_SWRESET};
  assign o_cmd_valid = OFF;
  assign o_cmd_data  = 8'h00;
`endif

  // Outputs are registered from the next state so they match a decode of r_state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_resx  <= HIGH;
      r_busy  <= OFF;
      r_done  <= OFF;
    end else begin
      r_state <= w_nxt;
      r_resx  <= (w_nxt == ST_PULSE) ? LOW : HIGH;
      r_busy  <= (w_nxt != ST_IDLE);
      r_done  <= (w_nxt == ST_DONE);
    end
  end

  assign o_resx = r_resx;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule
